// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC SPI capture block.
// Holds the FSM state encoding, the default parameter values used by
// adc_spi_capture and sclk_div, and a helper that sizes counters so a
// parameter of 1 still yields a legal one-bit vector.
package adc_spi_pkg;

  // Default SCLK half-period in clk cycles.
  localparam int DEF_CLK_DIV    = 4;
  // Default SCLK cycles per conversion frame.
  localparam int DEF_FRAME_BITS = 16;
  // Default number of leading frame bits that are discarded.
  localparam int DEF_LEAD_BITS  = 4;
  // Default number of data bits captured after the lead bits.
  localparam int DEF_DATA_BITS  = 12;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } state_t;

  // Width needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sclk_div.sv
// SCLK half-period divider.
// Counts clk cycles while enabled and pulses tick on the last cycle of every
// CLK_DIV-cycle phase. The count restarts from zero whenever en drops, so a
// fresh phase always begins exactly CLK_DIV cycles before its tick.
//
// Ports:
//   clk   - sole clock, posedge
//   rst_n - asynchronous active-low reset
//   en    - count enable; low clears the counter
//   tick  - high during the final cycle of each half-period
module sclk_div
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            DW   = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt_r;

  // Half-period counter: runs 0..CLK_DIV-1 while enabled, then restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!en || (cnt_r == LAST)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + DW'(1);
    end
  end

  assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/adc_spi_capture.sv
// SPI master that reads one conversion frame from a serial ADC per start
// request. The frame is FRAME_BITS SCLK cycles long; the first LEAD_BITS
// bits and any bits after LEAD_BITS+DATA_BITS are dropped, the rest are
// collected MSB-first and presented on data_out with a one-cycle valid.
//
// Ports:
//   clk      - sole clock, posedge
//   rst_n    - asynchronous active-low reset
//   start    - one-cycle conversion request, honoured only when idle
//   sdata    - ADC serial data, sampled as sclk is driven high
//   cs_n     - ADC chip select, active low (flop output)
//   sclk     - ADC serial clock, idles high (flop output)
//   busy     - conversion in progress (SETUP, SHIFT, QUIET)
//   data_out - last completed sample, held between valid pulses
//   valid    - one-cycle pulse when data_out is updated
module adc_spi_capture
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int LEAD_BITS  = DEF_LEAD_BITS,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sdata,
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid
);

  localparam int            BW       = cnt_width(FRAME_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  state_t               state_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 quiet_half_r;

  logic div_en_s;
  logic tick_s;
  logic keep_bit_s;

  // The divider idles in IDLE and also during the valid cycle, so QUIET
  // spends a full 2*CLK_DIV cycles after the cycle that delivers the data.
  assign div_en_s = (state_r != IDLE) && !valid;

  sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en_s),
    .tick  (tick_s)
  );

  // Only the data window of the frame reaches the shift register.
  assign keep_bit_s = (int'(bit_cnt_r) >= LEAD_BITS) &&
                      (int'(bit_cnt_r) <  (LEAD_BITS + DATA_BITS));

  // Conversion sequencer with registered SPI pins, status and data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cs_n         <= 1'b1;
      sclk         <= 1'b1;
      busy         <= 1'b0;
      valid        <= 1'b0;
      data_out     <= '0;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      quiet_half_r <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_r)
        IDLE: begin
          cs_n         <= 1'b1;
          sclk         <= 1'b1;
          bit_cnt_r    <= '0;
          quiet_half_r <= 1'b0;
          if (start) begin
            state_r <= SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            shift_r <= '0;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end

        SETUP: begin
          // cs_n is already low; hold sclk high for one half-period.
          if (tick_s) begin
            state_r   <= SHIFT;
            sclk      <= 1'b0;
            bit_cnt_r <= '0;
          end else begin
            state_r <= SETUP;
          end
        end

        SHIFT: begin
          if (tick_s) begin
            if (!sclk) begin
              // End of low phase: raise sclk and sample the bit the ADC
              // presented on the preceding falling edge.
              sclk <= 1'b1;
              if (keep_bit_s) begin
                shift_r <= (shift_r << 1) | DATA_BITS'(sdata);
              end else begin
                shift_r <= shift_r;
              end
            end else if (bit_cnt_r == LAST_BIT) begin
              // End of the final high phase: release the ADC and publish.
              state_r  <= QUIET;
              cs_n     <= 1'b1;
              valid    <= 1'b1;
              data_out <= shift_r;
            end else begin
              bit_cnt_r <= bit_cnt_r + BW'(1);
              sclk      <= 1'b0;
            end
          end else begin
            state_r <= SHIFT;
          end
        end

        QUIET: begin
          // Two divider phases of recovery time before the next frame.
          if (tick_s) begin
            if (quiet_half_r) begin
              state_r      <= IDLE;
              busy         <= 1'b0;
              quiet_half_r <= 1'b0;
            end else begin
              quiet_half_r <= 1'b1;
            end
          end else begin
            state_r <= QUIET;
          end
        end

        default: begin
          state_r      <= IDLE;
          cs_n         <= 1'b1;
          sclk         <= 1'b1;
          busy         <= 1'b0;
          bit_cnt_r    <= '0;
          quiet_half_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Self-checking bench for adc_spi_capture: one instance at default
// parameters, one with CLK_DIV=1. An ADC model per instance shifts a frame
// out MSB-first on sclk falling edges; expected data and timing come from
// the frame layout and divider arithmetic.
module tb_adc_spi_capture;

  localparam int FB = 16;
  localparam int LB = 4;
  localparam int DB = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic          start0 = 1'b0, sdata0 = 1'b0, start1 = 1'b0, sdata1 = 1'b0;
  logic          cs_n0, sclk0, busy0, valid0;
  logic          cs_n1, sclk1, busy1, valid1;
  logic [DB-1:0] dout0, dout1;

  adc_spi_capture #(.CLK_DIV(4), .FRAME_BITS(FB), .LEAD_BITS(LB), .DATA_BITS(DB)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sdata(sdata0), .cs_n(cs_n0),
    .sclk(sclk0), .busy(busy0), .data_out(dout0), .valid(valid0));

  adc_spi_capture #(.CLK_DIV(1), .FRAME_BITS(FB), .LEAD_BITS(LB), .DATA_BITS(DB)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sdata(sdata1), .cs_n(cs_n1),
    .sclk(sclk1), .busy(busy1), .data_out(dout1), .valid(valid1));

  // ADC models: bit k of the frame appears on the k-th sclk falling edge.
  logic [FB-1:0] frame0 = '0, frame1 = '0;
  int k0 = 0, k1 = 0, rises0 = 0, rises1 = 0;

  always @(negedge cs_n0) k0 = 0;
  always @(negedge sclk0) begin
    if (k0 < FB) sdata0 = frame0[FB-1-k0];
    k0++;
  end
  always @(posedge sclk0) rises0++;

  always @(negedge cs_n1) k1 = 0;
  always @(negedge sclk1) begin
    if (k1 < FB) sdata1 = frame1[FB-1-k1];
    k1++;
  end
  always @(posedge sclk1) rises1++;

  int errors = 0;
  int checks = 0;
  logic [DB-1:0] prev_data [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: data window of the frame, counted from the MSB side.
  function automatic logic [DB-1:0] model_data(input logic [FB-1:0] f);
    logic [FB-1:0] t;
    t = f >> (FB - LB - DB);
    return t[DB-1:0];
  endfunction

  function automatic int model_div(input int inst);
    return (inst == 0) ? 4 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int inst, output logic cs, output logic sc,
                        output logic bz, output logic vl, output logic [DB-1:0] d);
    if (inst == 0) begin
      cs = cs_n0; sc = sclk0; bz = busy0; vl = valid0; d = dout0;
    end else begin
      cs = cs_n1; sc = sclk1; bz = busy1; vl = valid1; d = dout1;
    end
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start0 = v;
    else           start1 = v;
  endtask

  function automatic int get_rises(input int inst);
    return (inst == 0) ? rises0 : rises1;
  endfunction

  // One conversion; starts are re-pulsed at cycles spam_a/spam_b (0 = none).
  task automatic do_frame(input int inst, input logic [FB-1:0] frame,
                          input int spam_a, input int spam_b, output int vcyc);
    int div, lat, quiet_end, nvalid, low, r0, toggles;
    bit busy_ok, held_ok, sclk_ok;
    logic cs, sc, bz, vl, last_sc;
    logic [DB-1:0] d, expd;
    div       = model_div(inst);
    lat       = 1 + div + 2 * div * FB;
    quiet_end = lat + 2 * div;
    expd      = model_data(frame);
    if (inst == 0) frame0 = frame;
    else           frame1 = frame;
    r0 = get_rises(inst);
    nvalid = 0; low = 0; toggles = 0; vcyc = -1;
    busy_ok = 1'b1; held_ok = 1'b1; sclk_ok = 1'b1;
    last_sc = 1'b1;
    set_start(inst, 1'b1);
    tick();
    set_start(inst, 1'b0);
    for (int n = 1; n <= quiet_end; n++) begin
      sample(inst, cs, sc, bz, vl, d);
      if (n == 1) begin
        check("setup_cs_n", cs, 1'b0);
        check("setup_sclk", sc, 1'b1);
      end
      if (!cs) low++;
      if (!bz) busy_ok = 1'b0;
      if (cs && !sc) sclk_ok = 1'b0;
      if (sc !== last_sc) toggles++;
      last_sc = sc;
      if (vl) begin
        nvalid++;
        vcyc = cyc;
        check("valid_cycle", n, lat);
        check("data_out", d, expd);
        prev_data[inst] = expd;
      end else if (d !== prev_data[inst]) begin
        held_ok = 1'b0;
      end
      set_start(inst, (n == spam_a) || (n == spam_b));
      tick();
    end
    set_start(inst, 1'b0);
    sample(inst, cs, sc, bz, vl, d);
    check("idle_busy", bz, 1'b0);
    check("idle_cs_n", cs, 1'b1);
    check("idle_valid", vl, 1'b0);
    check("valid_count", nvalid, 1);
    check("cs_low_len", low, lat - 1);
    check("sclk_rises", get_rises(inst) - r0, FB);
    check("sclk_toggles", toggles, 2 * FB);
    check("busy_held", busy_ok, 1'b1);
    check("data_held", held_ok, 1'b1);
    check("sclk_hi_when_desel", sclk_ok, 1'b1);
  endtask

  // Idle cycles: nothing may start on its own (no queued request).
  task automatic idle_gap(input int inst, input int ncyc);
    logic cs, sc, bz, vl;
    logic [DB-1:0] d;
    bit ok;
    ok = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      sample(inst, cs, sc, bz, vl, d);
      if (!cs || !sc || bz || vl || (d !== prev_data[inst])) ok = 1'b0;
      tick();
    end
    check("idle_quiet", ok, 1'b1);
  endtask

  // Start a frame and pull reset at cycle abort_n of it.
  task automatic reset_frame(input logic [FB-1:0] frame, input int abort_n);
    logic cs, sc, bz, vl;
    logic [DB-1:0] d;
    int nvalid;
    nvalid = 0;
    frame0 = frame;
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    for (int n = 1; n < abort_n; n++) begin
      sample(0, cs, sc, bz, vl, d);
      if (vl) nvalid++;
      tick();
    end
    sample(0, cs, sc, bz, vl, d);
    check("pre_rst_cs_low", cs, 1'b0);
    rst_n = 1'b0;
    #1;
    sample(0, cs, sc, bz, vl, d);
    check("rst_cs_n", cs, 1'b1);
    check("rst_sclk", sc, 1'b1);
    check("rst_busy", bz, 1'b0);
    check("rst_valid", vl, 1'b0);
    check("rst_data", d, 12'h000);
    prev_data[0] = '0;
    prev_data[1] = '0;
    for (int n = 0; n < 3; n++) begin
      tick();
      sample(0, cs, sc, bz, vl, d);
      if (vl) nvalid++;
    end
    #2 rst_n = 1'b1;
    #1;
    sample(0, cs, sc, bz, vl, d);
    check("post_rst_cs_n", cs, 1'b1);
    check("post_rst_busy", bz, 1'b0);
    tick();
    sample(0, cs, sc, bz, vl, d);
    if (vl) nvalid++;
    check("abort_no_valid", nvalid, 0);
    check("abort_stays_idle", bz, 1'b0);
  endtask

  initial begin
    int va, vb, vc, inst, div, qend, gap;
    logic cs, sc, bz, vl;
    logic [DB-1:0] d;
    prev_data[0] = '0;
    prev_data[1] = '0;

    repeat (3) @(posedge clk);
    #1;
    sample(0, cs, sc, bz, vl, d);
    check("reset_cs_n", cs, 1'b1);
    check("reset_sclk", sc, 1'b1);
    check("reset_busy", bz, 1'b0);
    check("reset_valid", vl, 1'b0);
    check("reset_data", d, 12'h000);
    #3 rst_n = 1'b1;
    tick();
    tick();

    // Basic frame with starts during the frame that must be ignored.
    do_frame(0, 16'h0ABC, 10, 132, vc);
    idle_gap(0, 20);

    // Mid-frame reset, then a clean frame.
    reset_frame(16'h0ABC, 60);
    do_frame(0, 16'h0555, 0, 0, vc);
    idle_gap(0, 4);

    // Back-to-back conversions.
    do_frame(0, 16'h0FFF, 0, 0, va);
    do_frame(0, 16'h0001, 0, 0, vb);
    check("b2b_gap", vb - va, 142);
    idle_gap(0, 4);

    // Fastest divider.
    do_frame(1, 16'h0800, 0, 0, vc);
    idle_gap(1, 4);

    // Lead and trailing bits set, data window all zero.
    do_frame(0, 16'hF000, 0, 0, vc);
    idle_gap(0, 3);

    // Randomized frames, ignored starts and idle gaps on both instances.
    for (int i = 0; i < 10; i++) begin
      inst = i % 2;
      div  = model_div(inst);
      qend = 1 + div + 2 * div * FB + 2 * div;
      do_frame(inst, FB'($urandom), $urandom_range(qend, 1), $urandom_range(qend, 1), vc);
      gap = $urandom_range(3, 0);
      if (gap > 0) idle_gap(inst, gap);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_spi_capture.md
ADC_SPI_CAPTURE -- requirements
Module: adc_spi_capture

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have parameter FRAME_BITS, default 16: SCLK cycles per conversion frame.
REQ-003 SHALL have parameter LEAD_BITS, default 4: frame bits discarded before data.
REQ-004 SHALL have parameter DATA_BITS, default 12: bits captured MSB-first after LEAD_BITS; LEAD_BITS+DATA_BITS <= FRAME_BITS.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle conversion request (edge-detector enable pulse).
REQ-008 SHALL have port sdata  input  1  ADC serial data.
REQ-009 SHALL have port cs_n  output  1  ADC chip select, active low.
REQ-010 SHALL have port sclk  output  1  ADC serial clock, idles high.
REQ-011 SHALL have port busy  output  1  high from the cycle after accepted start until return to IDLE.
REQ-012 SHALL have port data_out  output  DATA_BITS  last captured sample.
REQ-013 SHALL have port valid  output  1  one-cycle pulse marking new data_out.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, SHIFT, QUIET.
REQ-015 IDLE: cs_n=1, sclk=1, busy=0; start=1 -> SETUP next cycle; start=0 -> stay.
REQ-016 SETUP: cs_n=0, sclk=1, lasts exactly CLK_DIV cycles, then -> SHIFT.
REQ-017 SHIFT: per bit, sclk=0 for CLK_DIV cycles then sclk=1 for CLK_DIV cycles; exactly FRAME_BITS bits.
REQ-018 sdata SHALL be sampled on the clk edge at which sclk is driven 0->1; bit index counts 0..FRAME_BITS-1.
REQ-019 Bits with index < LEAD_BITS or >= LEAD_BITS+DATA_BITS SHALL be discarded; the others shift into a DATA_BITS register MSB-first.
REQ-020 After the high phase of the final bit: cs_n=1, valid=1 for that cycle, data_out updated in the same cycle; state -> QUIET.
REQ-021 data_out SHALL hold its value between valid pulses; the shift register SHALL NOT be visible on data_out mid-frame.
REQ-022 QUIET: cs_n=1, sclk=1, busy=1, lasts 2*CLK_DIV cycles, then -> IDLE.
REQ-023 Latency, start-accepted cycle to valid: 1 + CLK_DIV + 2*CLK_DIV*FRAME_BITS cycles (133 at defaults).
REQ-024 start while busy=1 (SETUP/SHIFT/QUIET) SHALL be ignored and not queued.
REQ-025 start in the first IDLE cycle after QUIET SHALL be accepted (back-to-back conversions).
REQ-026 sclk and cs_n SHALL be driven directly from flops (glitch-free).
REQ-027 Divider and bit counters SHALL be sized by $clog2 of their parameters and SHALL NOT wrap mid-frame.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, cs_n=1, sclk=1, busy=0, valid=0, data_out=0, counters=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no valid pulse; first post-reset start begins a fresh frame.
REQ-030 Outputs SHALL hold reset values until the first clk edge after rst_n deasserts.

Structure
REQ-031 Package adc_spi_pkg SHALL hold the FSM state enum typedef and the default parameter constants.
REQ-032 One sub-module, sclk_div, SHALL hold the half-period counter and emit phase-tick pulses; FSM and shift register stay in adc_spi_capture.

Verification
REQ-033 Defaults, ADC model drives frame 0x0ABC MSB-first on sclk falling edges, one start -> valid at cycle 133, data_out=0xABC, 16 sclk rising edges.
REQ-034 start pulsed again at cycles 10 and 132 after first start -> ignored; exactly one valid, cs_n single low window of 132 cycles.
REQ-035 rst_n low at cycle 60 of a frame -> cs_n=1, sclk=1, busy=0 immediately; no valid; next frame 0x0555 -> data_out=0x555.
REQ-036 Two starts, second in first IDLE cycle after QUIET -> two valid pulses 142 cycles apart, data 0xFFF then 0x001.
REQ-037 CLK_DIV=1, frame 0x0800 -> sclk toggles every cycle, valid at cycle 34, data_out=0x800.
REQ-038 Lead/trail bits driven 1 with data 0x000 (frame 0xF000) -> data_out=0x000.
